uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmitter that is the counterpart of the team's UART receiver.
- Accepts a parallel word over a valid/busy handshake.
- Serialises it as start bit, DATA_WIDTH data bits (LSB first), optional parity bit and one stop bit.
- Each bit is held for Prescale clock cycles; parity settings match the receiver's PAR_EN/PAR_TYP conventions.
- Sits in the UART block beside the receiver and drives the serial line directly.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9).

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel word to send; sampled when accepted
Data_Valid  input  1  request to send P_DATA; accepted when high at a rising edge with busy low
PAR_EN  input  1  1 = parity bit inserted after the data bits
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  6  clock cycles per bit; 0 treated as 1
TX_OUT  output  1  serial line, idles high
busy  output  1  1 = new Data_Valid will not be accepted

Behaviour:
- Reset (asynchronous, any time incl. mid-frame): TX_OUT=1, busy=0, state=IDLE, all counters and registers cleared. No partial frame resumes after reset release.
- Acceptance: Data_Valid=1 and busy=0 at edge N.
  - P_DATA, PAR_EN, PAR_TYP and Prescale are latched at edge N; input changes afterwards have no effect on the frame in flight.
  - Parity is computed from the latched data: XOR of all bits, inverted when PAR_TYP=1.
  - From edge N (registered): TX_OUT=0 (start bit) and busy=1.
- States:
  - IDLE: TX_OUT=1, busy=0. Goes to START on acceptance.
  - START: TX_OUT=0 for P cycles, then DATA.
  - DATA: bit i driven for P cycles, i=0..DATA_WIDTH-1 (LSB first). After the last bit, goes to PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: TX_OUT = parity bit for P cycles, then STOP.
  - STOP: TX_OUT=1 for P cycles, then IDLE.
- Bit timing: P = latched Prescale (0 maps to 1). An edge counter runs 0..P-1 and a bit counter advances on terminal count; both reset on entry to START. No drift: each bit lasts exactly P cycles.
- Frame length: (2 + DATA_WIDTH + PAR_EN) × P cycles. busy is high for exactly that many cycles and falls on the edge that ends STOP. Minimum 1 idle cycle between frames (build without the optional feature).
- Data_Valid while busy=1: ignored, no state change. Data_Valid held high continuously: the next frame is accepted on the first edge with busy=0.
- TX_OUT and busy come straight from flops (glitch-free).

Optional Feature:
Macro UART_TX_HOLD_EN — one-entry holding register for back-to-back frames.
- Defined:
  - busy means "holding register full" (not "frame active").
  - A Data_Valid accepted while a frame is in flight captures P_DATA/PAR_EN/PAR_TYP/Prescale into the holding register.
  - At the end of STOP with the register full, the next START begins on the following cycle with no idle gap, and the register empties.
  - busy falls on that same edge.
  - Reset clears the holding register.
- Undefined: no holding register; busy equals "state != IDLE", exactly as in Behaviour.

Test Plan:
1. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 → TX_OUT bits 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop), each exactly 8 cycles; busy high 88 cycles.
2. Same as 1 with PAR_TYP=1 → parity bit 1. With PAR_EN=0 → no parity slot, stop directly after bit 7, busy high 80 cycles.
3. Prescale=0, P_DATA=0xFF, PAR_EN=0 → each bit 1 cycle, frame 10 cycles, TX_OUT 0 then nine 1s.
4. Start frame 0x3C (Prescale=4). Pulse Data_Valid with 0x55 mid-frame and change P_DATA/Prescale mid-frame → the 0x3C frame is unaltered. Without UART_TX_HOLD_EN, 0x55 is never sent.
5. Assert RST during data bit 3 → TX_OUT=1 and busy=0 immediately (before the next clock edge). After release the line stays idle until a new Data_Valid.
6. UART_TX_HOLD_EN defined: send 0x12, then 0x34 during the 0x12 frame → stop bit of 0x12 followed immediately by start bit of 0x34 (zero idle cycles). busy high only from capture until that start; a third Data_Valid while the register is full is ignored.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_TX_HOLD_EN to add a one-entry holding register for gapless back-to-back frames.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic [5:0]            presc_q;
    logic [5:0]            edge_cnt;
    logic [5:0]            edge_cnt_next;
    logic [3:0]            bit_cnt;
    logic [3:0]            bit_cnt_next;
    logic                  tx_q;
    logic                  tx_next;
    logic                  busy_q;
    logic                  busy_next;
    logic                  term;
    logic                  shift_en;
    logic                  start_in;
    logic [5:0]            presc_in;
    logic                  par_in;

`ifdef UART_TX_HOLD_EN
    logic                  hold_full;
    logic                  hold_full_next;
    logic                  start_hold;
    logic                  capture;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_par_en;
    logic                  hold_par_bit;
    logic [5:0]            hold_presc;
`endif

    assign presc_in = (Prescale == 6'd0) ? 6'd1 : Prescale;
    assign par_in   = (^P_DATA) ^ PAR_TYP;
    assign term     = (edge_cnt == (presc_q - 6'd1));

    always_comb begin
        state_next    = state;
        edge_cnt_next = edge_cnt + 6'd1;
        bit_cnt_next  = bit_cnt;
        tx_next       = tx_q;
        shift_en      = 1'b0;
        start_in      = 1'b0;
`ifdef UART_TX_HOLD_EN
        start_hold     = 1'b0;
        capture        = 1'b0;
        hold_full_next = hold_full;
`endif
        case (state)
            IDLE: begin
                edge_cnt_next = 6'd0;
                tx_next       = 1'b1;
                if (Data_Valid) begin
                    start_in = 1'b1;
                end
            end
            START: begin
                if (term) begin
                    state_next    = DATA;
                    edge_cnt_next = 6'd0;
                    tx_next       = shreg[0];
                end
            end
            DATA: begin
                if (term) begin
                    edge_cnt_next = 6'd0;
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state_next = PARITY;
                            tx_next    = par_bit_q;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        // shreg[0] is on the line now, so shreg[1] is the next bit out
                        bit_cnt_next = bit_cnt + 4'd1;
                        shift_en     = 1'b1;
                        tx_next      = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (term) begin
                    state_next    = STOP;
                    edge_cnt_next = 6'd0;
                    tx_next       = 1'b1;
                end
            end
            STOP: begin
                if (term) begin
                    state_next    = IDLE;
                    edge_cnt_next = 6'd0;
                    tx_next       = 1'b1;
`ifdef UART_TX_HOLD_EN
                    if (hold_full) begin
                        start_hold = 1'b1;
                    end else if (Data_Valid) begin
                        start_in = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        if (start_in) begin
            state_next    = START;
            edge_cnt_next = 6'd0;
            bit_cnt_next  = 4'd0;
            tx_next       = 1'b0;
        end

`ifdef UART_TX_HOLD_EN
        if (start_hold) begin
            state_next     = START;
            edge_cnt_next  = 6'd0;
            bit_cnt_next   = 4'd0;
            tx_next        = 1'b0;
            hold_full_next = 1'b0;
        end
        capture = Data_Valid && !hold_full && (state != IDLE) && !start_in;
        if (capture) begin
            hold_full_next = 1'b1;
        end
        busy_next = hold_full_next;
`else
        busy_next = (state_next != IDLE);
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            edge_cnt  <= 6'd0;
            bit_cnt   <= 4'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= 6'd0;
        end else begin
            state    <= state_next;
            edge_cnt <= edge_cnt_next;
            bit_cnt  <= bit_cnt_next;
            tx_q     <= tx_next;
            busy_q   <= busy_next;
            if (start_in) begin
                shreg     <= P_DATA;
                par_en_q  <= PAR_EN;
                par_bit_q <= par_in;
                presc_q   <= presc_in;
            end
`ifdef UART_TX_HOLD_EN
            else if (start_hold) begin
                shreg     <= hold_data;
                par_en_q  <= hold_par_en;
                par_bit_q <= hold_par_bit;
                presc_q   <= hold_presc;
            end
`endif
            else if (shift_en) begin
                shreg <= shreg >> 1;
            end
        end
    end

`ifdef UART_TX_HOLD_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_full    <= 1'b0;
            hold_data    <= '0;
            hold_par_en  <= 1'b0;
            hold_par_bit <= 1'b0;
            hold_presc   <= 6'd0;
        end else begin
            hold_full <= hold_full_next;
            if (capture) begin
                hold_data    <= P_DATA;
                hold_par_en  <= PAR_EN;
                hold_par_bit <= par_in;
                hold_presc   <= presc_in;
            end
        end
    end
`endif

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame; expected frames are hand-written bit patterns
// (bit 0 = start, then data LSB first, optional parity, stop).
module tb_uart_tx_frame;

    localparam int DW = 8;
`ifdef UART_TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [5:0]    Prescale;
    logic          TX_OUT;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic tx_log   [0:127];
    logic busy_log [0:127];

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-edge Data_Valid pulse; returns on the negedge after the accepting edge.
    task automatic launch(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] p);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = p;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            tx_log[i]   = TX_OUT;
            busy_log[i] = busy;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd1;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: TX_OUT=%b busy=%b want 1/0", TX_OUT, busy);
        end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: TX_OUT=%b busy=%b want 1/0", TX_OUT, busy);
        end
    endtask

    task automatic test_parity_even();
        logic [15:0] exp;
        logic eb;
        exp = 16'(11'b1_0_10100101_0);
        eb  = HOLD ? 1'b0 : 1'b1;
        launch(8'hA5, 1'b1, 1'b0, 6'd8);
        record(90);
        for (int i = 0; i < 88; i++) begin
            checks++;
            if (tx_log[i] !== exp[i/8]) begin
                failures++;
                $display("FAIL even_tx sample %0d: got %b want %b", i, tx_log[i], exp[i/8]);
            end
            checks++;
            if (busy_log[i] !== eb) begin
                failures++;
                $display("FAIL even_busy sample %0d: got %b want %b", i, busy_log[i], eb);
            end
        end
        checks++;
        if (tx_log[88] !== 1'b1 || busy_log[88] !== 1'b0) begin
            failures++;
            $display("FAIL even_end: TX_OUT=%b busy=%b want 1/0", tx_log[88], busy_log[88]);
        end
    endtask

    task automatic test_parity_odd_and_off();
        logic [15:0] exp;
        logic eb;
        eb  = HOLD ? 1'b0 : 1'b1;
        exp = 16'(11'b1_1_10100101_0);
        launch(8'hA5, 1'b1, 1'b1, 6'd8);
        record(90);
        for (int i = 0; i < 88; i++) begin
            checks++;
            if (tx_log[i] !== exp[i/8]) begin
                failures++;
                $display("FAIL odd_tx sample %0d: got %b want %b", i, tx_log[i], exp[i/8]);
            end
        end
        checks++;
        if (tx_log[88] !== 1'b1 || busy_log[88] !== 1'b0 || busy_log[87] !== eb) begin
            failures++;
            $display("FAIL odd_end: TX_OUT=%b busy87=%b busy88=%b want 1/%b/0",
                     tx_log[88], busy_log[87], busy_log[88], eb);
        end

        exp = 16'(10'b1_10100101_0);
        launch(8'hA5, 1'b0, 1'b1, 6'd8);
        record(82);
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (tx_log[i] !== exp[i/8]) begin
                failures++;
                $display("FAIL nopar_tx sample %0d: got %b want %b", i, tx_log[i], exp[i/8]);
            end
            checks++;
            if (busy_log[i] !== eb) begin
                failures++;
                $display("FAIL nopar_busy sample %0d: got %b want %b", i, busy_log[i], eb);
            end
        end
        checks++;
        if (tx_log[80] !== 1'b1 || busy_log[80] !== 1'b0) begin
            failures++;
            $display("FAIL nopar_end: TX_OUT=%b busy=%b want 1/0", tx_log[80], busy_log[80]);
        end
    endtask

    task automatic test_prescale_zero();
        logic [15:0] exp;
        logic eb;
        eb  = HOLD ? 1'b0 : 1'b1;
        exp = 16'(10'b1_11111111_0);
        launch(8'hFF, 1'b0, 1'b0, 6'd0);
        record(12);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx_log[i] !== exp[i] || busy_log[i] !== eb) begin
                failures++;
                $display("FAIL p0 sample %0d: TX_OUT=%b busy=%b want %b/%b", i, tx_log[i], busy_log[i], exp[i], eb);
            end
        end
        checks++;
        if (tx_log[10] !== 1'b1 || busy_log[10] !== 1'b0) begin
            failures++;
            $display("FAIL p0_end: TX_OUT=%b busy=%b want 1/0", tx_log[10], busy_log[10]);
        end
    endtask

    task automatic test_input_stability();
        logic [15:0] exp;
        logic [15:0] exp2;
        logic eb;
        exp  = 16'(10'b1_00111100_0);
        exp2 = 16'(10'b1_01010101_0);
        launch(8'h3C, 1'b0, 1'b0, 6'd4);
        for (int i = 0; i < 60; i++) begin
            tx_log[i]   = TX_OUT;
            busy_log[i] = busy;
            if (i == 10) begin
                P_DATA = 8'h55; Prescale = 6'd1; Data_Valid = 1'b1;
            end else if (i == 11) begin
                Data_Valid = 1'b0;
            end else if (i == 20) begin
                P_DATA = 8'h00; Prescale = 6'd7; PAR_EN = 1'b1;
            end
            @(negedge CLK);
        end
        PAR_EN = 1'b0;
        for (int i = 0; i < 40; i++) begin
            eb = HOLD ? (i >= 11) : 1'b1;
            checks++;
            if (tx_log[i] !== exp[i/4] || busy_log[i] !== eb) begin
                failures++;
                $display("FAIL stable_3c sample %0d: TX_OUT=%b busy=%b want %b/%b",
                         i, tx_log[i], busy_log[i], exp[i/4], eb);
            end
        end
        for (int i = 40; i < 60; i++) begin
            checks++;
            if (HOLD && i < 50) begin
                if (tx_log[i] !== exp2[i-40] || busy_log[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL stable_55 sample %0d: TX_OUT=%b busy=%b want %b/0",
                             i, tx_log[i], busy_log[i], exp2[i-40]);
                end
            end else if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) begin
                failures++;
                $display("FAIL stable_idle sample %0d: TX_OUT=%b busy=%b want 1/0", i, tx_log[i], busy_log[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        launch(8'hA5, 1'b0, 1'b0, 6'd4);
        record(18);
        checks++;
        if (tx_log[17] !== 1'b0) begin
            failures++;
            $display("FAIL rst_bit3: TX_OUT=%b want 0", tx_log[17]);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: TX_OUT=%b busy=%b want 1/0", TX_OUT, busy);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        record(30);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (tx_log[i] !== 1'b1 || busy_log[i] !== 1'b0) begin
                failures++;
                $display("FAIL rst_idle sample %0d: TX_OUT=%b busy=%b want 1/0", i, tx_log[i], busy_log[i]);
            end
        end
        launch(8'h01, 1'b0, 1'b0, 6'd4);
        record(10);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_log[i] !== (i >= 4)) begin
                failures++;
                $display("FAIL rst_restart sample %0d: TX_OUT=%b want %b", i, tx_log[i], (i >= 4));
            end
        end
        repeat (40) @(negedge CLK);
    endtask

`ifdef UART_TX_HOLD_EN
    task automatic test_hold();
        logic [15:0] exp1;
        logic [15:0] exp2;
        logic eb;
        exp1 = 16'(10'b1_00010010_0);
        exp2 = 16'(10'b1_00110100_0);
        launch(8'h12, 1'b0, 1'b0, 6'd2);
        for (int i = 0; i < 42; i++) begin
            tx_log[i]   = TX_OUT;
            busy_log[i] = busy;
            if (i == 5) begin
                P_DATA = 8'h34; Data_Valid = 1'b1;
            end else if (i == 6) begin
                Data_Valid = 1'b0;
            end else if (i == 7) begin
                P_DATA = 8'h77; Data_Valid = 1'b1;
            end else if (i == 8) begin
                Data_Valid = 1'b0; P_DATA = 8'h00;
            end
            @(negedge CLK);
        end
        for (int i = 0; i < 42; i++) begin
            eb = (i >= 6 && i < 20);
            checks++;
            if (busy_log[i] !== eb) begin
                failures++;
                $display("FAIL hold_busy sample %0d: got %b want %b", i, busy_log[i], eb);
            end
            checks++;
            if (i < 20) begin
                if (tx_log[i] !== exp1[i/2]) begin
                    failures++;
                    $display("FAIL hold_12 sample %0d: got %b want %b", i, tx_log[i], exp1[i/2]);
                end
            end else if (i < 40) begin
                if (tx_log[i] !== exp2[(i-20)/2]) begin
                    failures++;
                    $display("FAIL hold_34 sample %0d: got %b want %b", i, tx_log[i], exp2[(i-20)/2]);
                end
            end else if (tx_log[i] !== 1'b1) begin
                failures++;
                $display("FAIL hold_idle sample %0d: got %b want 1", i, tx_log[i]);
            end
        end
    endtask
`else
    task automatic test_back_to_back();
        logic [15:0] exp;
        exp = 16'(10'b1_00001111_0);
        @(negedge CLK);
        P_DATA = 8'h0F; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd1; Data_Valid = 1'b1;
        @(negedge CLK);
        record(21);
        Data_Valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx_log[i] !== exp[i] || busy_log[i] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_first sample %0d: TX_OUT=%b busy=%b want %b/1", i, tx_log[i], busy_log[i], exp[i]);
            end
            checks++;
            if (tx_log[i+11] !== exp[i] || busy_log[i+11] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_second sample %0d: TX_OUT=%b busy=%b want %b/1",
                         i + 11, tx_log[i+11], busy_log[i+11], exp[i]);
            end
        end
        checks++;
        if (tx_log[10] !== 1'b1 || busy_log[10] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: TX_OUT=%b busy=%b want 1/0", tx_log[10], busy_log[10]);
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: TX_OUT=%b busy=%b want 1/0", TX_OUT, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_parity_even();
        test_parity_odd_and_off();
        test_prescale_zero();
        test_input_stability();
        test_reset_mid_frame();
`ifdef UART_TX_HOLD_EN
        test_hold();
`else
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
